mult_controller_taint1: RTL and testbench
=========================================

Name: mult_controller_taint1

Overview:
- FSM controller for the 1-bit taint-tracked sequential shift-and-add multiplier.
- Drives the datapath control strobes (mdld, mrld, rsclear, rsload, rsshr) and their taint bits.
- Reads the datapath's multiplierReg / multiplierReg_t and signals done.
- Sits directly upstream of the datapath; top-level wrapper connects the two port-for-port.

Parameters:
- WIDTH, 1024, operand width; must match datapath WIDTH; WIDTH >= 1.
- CW, max(1, $clog2(WIDTH)), bit-index counter width (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiplication; sampled only in IDLE.
- start_t  in  1  taint of start.
- multiplierReg  in  WIDTH  multiplier value held by the datapath.
- multiplierReg_t  in  1  taint of multiplierReg.
- mdld / mdld_t  out  1 / 1  load multiplicandReg; taint.
- mrld / mrld_t  out  1 / 1  load multiplierReg; taint.
- rsclear / rsclear_t  out  1 / 1  clear runningSumReg; taint.
- rsload / rsload_t  out  1 / 1  add multiplicandReg into runningSumReg; taint.
- rsshr / rsshr_t  out  1 / 1  shift runningSumReg right by 1; taint.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; product is valid on the datapath.
- done_t  out  1  taint of done and of the product timing.

Behaviour:
- States: IDLE, LOAD, CHECK, SHIFT, DONE. Registers: state, cnt[CW-1:0], state_t.
- Reset (rst_n low, async): state=IDLE, cnt=0, state_t=0. Every output reads 0.
- IDLE:
  - start=1 -> LOAD at the next edge; otherwise stay in IDLE.
  - start_t=1 at any edge while in IDLE sets state_t, whether or not start=1.
- LOAD: assert mdld, mrld, rsclear together for 1 cycle; cnt<=0; -> CHECK.
- CHECK: rsload = multiplierReg[cnt]; -> SHIFT. Only the combinational output decodes datapath data.
- SHIFT: assert rsshr; -> CHECK with cnt<=cnt+1, or -> DONE if cnt==WIDTH-1 (cnt<=0).
- rsload and rsshr are never high in the same cycle; the datapath gives rsshr priority.
- DONE: done=1 for 1 cycle; -> IDLE unconditionally. start held high is accepted on the next IDLE cycle.
- Latency: start sampled at edge E0. done is high in the cycle after edge E0+2*WIDTH+1. Total 2*WIDTH+2 cycles from start to back in IDLE.
- Result: runningSumReg equals multiplier*multiplicand, zero-extended, when done=1.
- start while busy is ignored and has no taint effect.
- Outputs are Moore-decoded from state, except rsload, which is state and multiplierReg[cnt].
- Taint rules:
  - In CHECK, if multiplierReg_t=1, set state_t at the edge (subsequent control flow is data-dependent).
  - state_t is sticky; only rst_n clears it.
  - mdld_t = mrld_t = rsclear_t = rsshr_t = done_t = state_t in every state, including IDLE.
  - rsload_t = state_t | (state==CHECK & multiplierReg_t).
- Reset mid-operation: immediate return to IDLE, all strobes low, taint cleared, no done pulse. Datapath contents are don't-care.
- WIDTH=1: cnt is 1 bit wide and stays 0; a single CHECK/SHIFT pair runs.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, LOAD=1, CHECK=2, SHIFT=3, DONE=4; 3-bit);
  - the CW width function, also used by the wrapper.
- No sub-module: the counter and taint register are a few lines each.
- Integration wrapper mult_top_taint1 (controller + datapath) is a separate file.

Test Plan (WIDTH=4 unless stated):
- Multiply: multiplier=13, multiplicand=11, start pulse, taints 0 -> rsload high in CHECK for bits 0, 2, 3 only; done in the 10th cycle after the start edge; product=143; every _t=0.
- Zero multiplier: multiplier=0, multiplicand=15 -> rsload never asserted; 4 rsshr pulses; product=0; done on the same cycle count.
- Max operands with back-to-back start: 15*15 with start held high -> product=225 at done; IDLE for exactly 1 cycle, then LOAD again.
- Tainted multiplier: multiplierReg_t=1 -> rsload_t=1 in the first CHECK. From the next edge, rsshr_t, done_t and all other _t read 1. They stay 1 in IDLE until rst_n.
- Tainted start: start=0, start_t=1 for 1 cycle in IDLE -> state_t=1; all _t outputs read 1 while idle. Pulsing rst_n clears them.
- Reset mid-operation: rst_n low during the 3rd CHECK -> outputs 0 asynchronously; state IDLE; no done pulse. A new start afterwards yields the correct 9*7=63.

Source files
------------

// File: rtl/mult_controller_taint1_pkg.sv
// Shared definitions for the taint-tracked shift-and-add multiplier:
// controller state encoding and the bit-index counter width helper.
package mult_controller_taint1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    // Counter must be at least one bit wide even for a 1-bit operand.
    function automatic int calc_cw(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_controller_taint1.sv
// FSM controller for the 1-bit taint-tracked sequential shift-and-add
// multiplier: sequences load/check/shift and tracks a sticky control taint.
module mult_controller_taint1
    import mult_controller_taint1_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic             multiplierReg_t,
    output logic             mdld,
    output logic             mdld_t,
    output logic             mrld,
    output logic             mrld_t,
    output logic             rsclear,
    output logic             rsclear_t,
    output logic             rsload,
    output logic             rsload_t,
    output logic             rsshr,
    output logic             rsshr_t,
    output logic             busy,
    output logic             done,
    output logic             done_t
);

    localparam int            CW       = calc_cw(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ctrl_state_e   r_state;
    ctrl_state_e   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_state_t;
    logic          w_state_t_next;
    logic          w_in_check;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_state_t <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_state_t <= w_state_t_next;
        end
    end

    // Taint is sticky: once control flow has depended on tainted data or a
    // tainted request, every later decision is considered tainted too.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_state_t_next = r_state_t;
        case (r_state)
            ST_IDLE: begin
                if (start_t) begin
                    w_state_t_next = 1'b1;
                end
                if (start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_cnt_next   = '0;
                w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (multiplierReg_t) begin
                    w_state_t_next = 1'b1;
                end
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt == LAST_IDX) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next   = r_cnt + CW'(1);
                    w_state_next = ST_CHECK;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_in_check = (r_state == ST_CHECK);

    assign mdld    = (r_state == ST_LOAD);
    assign mrld    = (r_state == ST_LOAD);
    assign rsclear = (r_state == ST_LOAD);
    assign rsload  = w_in_check & multiplierReg[r_cnt];
    assign rsshr   = (r_state == ST_SHIFT);
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);

    assign mdld_t    = r_state_t;
    assign mrld_t    = r_state_t;
    assign rsclear_t = r_state_t;
    assign rsshr_t   = r_state_t;
    assign done_t    = r_state_t;
    // rsload is the only output that decodes datapath data combinationally.
    assign rsload_t  = r_state_t | (w_in_check & multiplierReg_t);

endmodule

// File: tb/tb_mult_controller_taint1.sv
// Self-checking bench for mult_controller_taint1 (WIDTH=4) with a behavioural
// shift-and-add datapath model and arithmetic product reference.
module tb_mult_controller_taint1;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         start_t;
    logic [W-1:0] mr;
    logic         mr_t;
    logic [W-1:0] md;
    logic mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t;
    logic rsload, rsload_t, rsshr, rsshr_t, busy, done, done_t;

    logic [2*W:0] sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_controller_taint1 #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_t         (start_t),
        .multiplierReg   (mr),
        .multiplierReg_t (mr_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .busy            (busy),
        .done            (done),
        .done_t          (done_t)
    );

    // Behavioural datapath: shift has priority over add.
    always @(posedge clk) begin
        if (rsclear)     sum <= '0;
        else if (rsshr)  sum <= sum >> 1;
        else if (rsload) sum <= sum + ((2*W+1)'(md) << W);
    end

    function automatic logic [12:0] all_outs();
        return {mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload,
                rsload_t, rsshr, rsshr_t, busy, done, done_t};
    endfunction

    function automatic logic [5:0] all_taints();
        return {mdld_t, mrld_t, rsclear_t, rsshr_t, done_t, rsload_t};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One multiplication. taint_from: first cycle (1 = cycle after start edge)
    // in which the sticky taint is expected; poke drives a tainted start
    // request while busy, which must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input bit tmr, input int taint_from,
                          input bit poke, input string name);
        int           done_n;
        int           shr_cnt;
        int           ld_cnt;
        logic [W-1:0] mask;
        bit           exp_t;
        bit           in_check;
        logic [2*W:0] exp_sum;
        mr = a; md = b; mr_t = tmr;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        done_n = 0; shr_cnt = 0; ld_cnt = 0; mask = '0;
        for (int n = 1; n <= 2*W + 4 && done_n == 0; n++) begin
            @(negedge clk);
            exp_t    = (n >= taint_from);
            in_check = (n >= 2) && (n <= 2*W) && (n % 2 == 0);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", name, n, busy);
            end
            checks++;
            if ((rsload & rsshr) !== 1'b0) begin
                errors++;
                $display("FAIL %s rsload&rsshr cycle %0d: got 1 expected 0", name, n);
            end
            checks++;
            if ({mdld_t, mrld_t, rsclear_t, rsshr_t, done_t} !== {5{exp_t}}) begin
                errors++;
                $display("FAIL %s taints cycle %0d: got %b expected %b", name, n,
                         {mdld_t, mrld_t, rsclear_t, rsshr_t, done_t}, {5{exp_t}});
            end
            checks++;
            if (rsload_t !== (exp_t | (in_check & tmr))) begin
                errors++;
                $display("FAIL %s rsload_t cycle %0d: got %b expected %b", name, n,
                         rsload_t, exp_t | (in_check & tmr));
            end
            if (rsload === 1'b1 && shr_cnt < W) mask[shr_cnt] = 1'b1;
            if (rsshr === 1'b1) shr_cnt++;
            if (mdld === 1'b1 && mrld === 1'b1 && rsclear === 1'b1) ld_cnt++;
            if (done === 1'b1) done_n = n;
            if (poke && n == 4) begin start = 1'b1; start_t = 1'b1; end
            if (poke && n == 5) begin start = 1'b0; start_t = 1'b0; end
        end
        exp_sum = (2*W+1)'(a) * (2*W+1)'(b);
        checks++;
        if (done_n != 2*W + 2) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_n, 2*W + 2);
        end
        checks++;
        if (mask !== a) begin
            errors++;
            $display("FAIL %s rsload_bits: got %b expected %b", name, mask, a);
        end
        checks++;
        if (shr_cnt != W || ld_cnt != 1) begin
            errors++;
            $display("FAIL %s strobe_counts: got shr=%0d ld=%0d expected shr=%0d ld=1",
                     name, shr_cnt, ld_cnt, W);
        end
        checks++;
        if (sum !== exp_sum) begin
            errors++;
            $display("FAIL %s product: got %0d expected %0d", name, sum, exp_sum);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after_done: got busy=%b expected 0", name, busy);
        end
        @(negedge clk);
        if (hold) begin
            checks++;
            if ({busy, mdld, mrld, rsclear} !== 4'b1111) begin
                errors++;
                $display("FAIL %s reload: got %b expected 1111", name,
                         {busy, mdld, mrld, rsclear});
            end
            start = 1'b0;
            done_n = 0;
            for (int n = 0; n < 3*W + 6 && done_n == 0; n++) begin
                @(negedge clk);
                if (done === 1'b1) done_n = 1;
            end
            checks++;
            if (done_n != 1) begin
                errors++;
                $display("FAIL %s second_done: got none expected pulse", name);
            end
            @(negedge clk);
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s stay_idle: got busy=%b expected 0", name, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_t = 1'b0; mr = '0; md = '0; mr_t = 1'b0;
        #12;
        checks++;
        if (all_outs() !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outs() !== 13'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected 0", all_outs());
        end
    endtask

    task automatic test_multiply();
        run_op(4'd13, 4'd11, 1'b0, 1'b0, 99, 1'b0, "mul13x11");
    endtask

    task automatic test_zero();
        run_op(4'd0, 4'd15, 1'b0, 1'b0, 99, 1'b0, "zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                   1'b0, 1'b0, 99, 1'b0, "random");
        end
    endtask

    task automatic test_busy_start();
        run_op(4'd6, 4'd5, 1'b0, 1'b0, 99, 1'b1, "busy_start");
    endtask

    task automatic test_back_to_back();
        run_op(4'd15, 4'd15, 1'b1, 1'b0, 99, 1'b0, "b2b");
    endtask

    task automatic test_taint_mult();
        run_op(4'd5, 4'd3, 1'b0, 1'b1, 3, 1'b0, "taint_mr");
        mr_t = 1'b0;
        @(negedge clk);
        checks++;
        if (all_taints() !== 6'b111111) begin
            errors++;
            $display("FAIL taint_mr_idle: got %b expected 111111", all_taints());
        end
        do_reset();
        checks++;
        if (all_taints() !== 6'b000000) begin
            errors++;
            $display("FAIL taint_mr_cleared: got %b expected 000000", all_taints());
        end
    endtask

    task automatic test_taint_start();
        @(negedge clk);
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        checks++;
        if ({busy, all_taints()} !== 7'b0111111) begin
            errors++;
            $display("FAIL taint_start: got %b expected 0111111", {busy, all_taints()});
        end
        do_reset();
        checks++;
        if (all_taints() !== 6'b000000) begin
            errors++;
            $display("FAIL taint_start_cleared: got %b expected 000000", all_taints());
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        mr = 4'd9; md = 4'd7; mr_t = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 6; n++) @(negedge clk);
        checks++;
        if ({busy, rsload} !== 2'b10) begin
            errors++;
            $display("FAIL mid_third_check: got %b expected 10", {busy, rsload});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got %b expected 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 2*W + 4; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL mid_reset_quiet: got activity expected idle");
        end
        run_op(4'd9, 4'd7, 1'b0, 1'b0, 99, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_zero();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_taint_mult();
        test_taint_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
